// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, zone encodings and segment masks for the 7-segment scanner
package sseg_pkg;

  localparam int NUM_DIGITS      = 8;
  localparam int ZONES_PER_DIGIT = 3;
  localparam int NUM_ZONES       = NUM_DIGITS * ZONES_PER_DIGIT;
  localparam int DEPTH_W         = 8;

  typedef enum logic [1:0] {
    ZONE_L = 2'd0,
    ZONE_M = 2'd1,
    ZONE_R = 2'd2
  } zone_e;

  typedef logic [DEPTH_W-1:0] depth_t;

  // Active-high masks in {dp,g,f,e,d,c,b,a} order; the output stage inverts them.
  localparam logic [7:0] SEG_L    = 8'b0011_0000;
  localparam logic [7:0] SEG_M    = 8'b0100_1001;
  localparam logic [7:0] SEG_R    = 8'b0000_0110;
  localparam logic [7:0] SSEG_OFF = 8'hFF;

  function automatic logic [7:0] zone_mask(input zone_e z);
    logic [7:0] m;
    m = 8'h00;
    case (z)
      ZONE_L:  m = SEG_L;
      ZONE_M:  m = SEG_M;
      ZONE_R:  m = SEG_R;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every PRESCALE clocks
module tick_gen #(
  parameter int PRESCALE = 244
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/pwm_sseg_scanner.sv
// rtl/pwm_sseg_scanner.sv - PWM-dimmed, time-multiplexed 8-digit 7-segment scanner with per-frame shadow brightness
module pwm_sseg_scanner
  import sseg_pkg::*;
#(
  parameter int PRESCALE    = 244,
  parameter int BLANK_TICKS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_ZONES*DEPTH_W-1:0]   depth_flat,
  output logic [7:0]                     sseg,
  output logic [7:0]                     digit,
  output logic                           frame_start
);

  localparam logic [7:0] BLANK = 8'(BLANK_TICKS);

  logic       tick;
  logic       presc_zero;
  logic [7:0] pwm_cnt;
  logic [2:0] dig;
  logic       boundary;
  depth_t     shadow [NUM_ZONES];
  logic [7:0] seg_on;
  logic [7:0] sseg_nxt;
  logic [7:0] digit_nxt;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // The prescaler sits at zero right after reset and right after every tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_zero <= 1'b1;
    end else begin
      presc_zero <= tick;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= 8'd0;
      dig     <= 3'd0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        dig <= dig + 3'd1;
      end
    end
  end

  assign boundary = presc_zero && (pwm_cnt == 8'd0) && (dig == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_ZONES; k++) begin
        shadow[k] <= '0;
      end
    end else if (boundary) begin
      for (int k = 0; k < NUM_ZONES; k++) begin
        shadow[k] <= depth_flat[DEPTH_W*k +: DEPTH_W];
      end
    end
  end

  always_comb begin
    seg_on    = 8'h00;
    sseg_nxt  = SSEG_OFF;
    digit_nxt = SSEG_OFF;
    if (pwm_cnt >= BLANK) begin
      digit_nxt = ~(8'b1 << dig);
      for (int z = 0; z < ZONES_PER_DIGIT; z++) begin
        if (pwm_cnt < shadow[5'(ZONES_PER_DIGIT * int'(dig) + z)]) begin
          seg_on = seg_on | zone_mask(zone_e'(2'(z)));
        end
      end
      sseg_nxt = ~seg_on;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sseg        <= SSEG_OFF;
      digit       <= SSEG_OFF;
      frame_start <= 1'b0;
    end else begin
      sseg        <= sseg_nxt;
      digit       <= digit_nxt;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_sseg_scanner.sv
// tb/tb_pwm_sseg_scanner.sv - scoreboard bench for pwm_sseg_scanner at PRESCALE=1, BLANK_TICKS=2
module tb_pwm_sseg_scanner;

  typedef struct packed {
    logic [7:0] sseg;
    logic [7:0] digit;
    logic       fs;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [191:0] depth_flat = '0;
  logic [7:0]   sseg;
  logic [7:0]   digit;
  logic         frame_start;

  obs_t       sbq[$];
  obs_t       exp_o;
  int         total = 0;
  int         bad = 0;
  int         edge_cnt = 0;
  logic [7:0] m_shadow [24];

  pwm_sseg_scanner #(
    .PRESCALE    (1),
    .BLANK_TICKS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .depth_flat  (depth_flat),
    .sseg        (sseg),
    .digit       (digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic obs_t obs();
    return {sseg, digit, frame_start};
  endfunction

  // Expected output for this edge from the cycle index since reset release.
  task automatic model_edge();
    int         pwm;
    int         dg;
    obs_t       e;
    logic [7:0] lit;
    pwm  = edge_cnt % 256;
    dg   = (edge_cnt / 256) % 8;
    e.fs = (edge_cnt % 2048 == 0);
    if (pwm < 2) begin
      e.sseg  = 8'hFF;
      e.digit = 8'hFF;
    end else begin
      e.digit     = 8'hFF;
      e.digit[dg] = 1'b0;
      lit = 8'h00;
      if (pwm < m_shadow[3*dg])   lit[5:4] = 2'b11;
      if (pwm < m_shadow[3*dg+1]) begin lit[0] = 1'b1; lit[6] = 1'b1; lit[3] = 1'b1; end
      if (pwm < m_shadow[3*dg+2]) lit[2:1] = 2'b11;
      e.sseg = ~lit;
    end
    if (e.fs) begin
      for (int k = 0; k < 24; k++) m_shadow[k] = depth_flat[8*k +: 8];
    end
    sbq.push_back(e);
    edge_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    if (reset) exp_o = sbq.pop_front();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    edge_cnt = 0;
    sbq.delete();
    for (int k = 0; k < 24; k++) m_shadow[k] = 8'h00;
  endtask

  task automatic test_reset();
    int pulses;
    int first_at;
    int last_at;
    int bad_gap;
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (obs() !== obs_t'({8'hFF, 8'hFF, 1'b0})) begin
        bad++;
        $display("FAIL reset_hold got=%h/%h/%b exp=FF/FF/0", sseg, digit, frame_start);
      end
    end
    release_reset();
    pulses = 0; first_at = -1; last_at = -1; bad_gap = 0;
    for (int i = 0; i < 4100; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL reset_scan i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (frame_start === 1'b1) begin
        if (first_at < 0) first_at = i;
        if (last_at >= 0 && i - last_at != 2048) bad_gap++;
        last_at = i;
        pulses++;
      end
    end
    total++;
    if (pulses != 3 || first_at != 0 || bad_gap != 0) begin
      bad++;
      $display("FAIL frame_pulses got=%0d first=%0d badgap=%0d exp=3 first=0 badgap=0", pulses, first_at, bad_gap);
    end
  endtask

  task automatic test_dark_scan();
    int low_cnt [8];
    int seg_on;
    depth_flat = '0;
    while (edge_cnt % 2048 != 0) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL dark_pre got=%h/%h/%b exp=%h/%h/%b", sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
    end
    for (int d = 0; d < 8; d++) low_cnt[d] = 0;
    seg_on = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL dark_scan i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      for (int d = 0; d < 8; d++) if (digit[d] === 1'b0) low_cnt[d]++;
      if (sseg !== 8'hFF) seg_on++;
    end
    for (int d = 0; d < 8; d++) begin
      total++;
      if (low_cnt[d] != 254) begin
        bad++;
        $display("FAIL dark_digit_low d=%0d got=%0d exp=254", d, low_cnt[d]);
      end
    end
    total++;
    if (seg_on != 0) begin
      bad++;
      $display("FAIL dark_seg_lit got=%0d exp=0", seg_on);
    end
  endtask

  task automatic test_single_zone();
    int lit1;
    int other;
    depth_flat = '0;
    depth_flat[8*4 +: 8] = 8'd128;
    while (edge_cnt % 2048 != 0) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL zone4_pre got=%h/%h/%b exp=%h/%h/%b", sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
    end
    lit1 = 0; other = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL zone4_scan i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (digit === 8'hFD && sseg === 8'hB6) lit1++;
      else if (sseg !== 8'hFF) other++;
    end
    total++;
    if (lit1 != 126 || other != 0) begin
      bad++;
      $display("FAIL zone4_duty got=%0d other=%0d exp=126 other=0", lit1, other);
    end
  endtask

  task automatic test_full_and_min();
    int lit7;
    int lit0;
    depth_flat = '0;
    depth_flat[8*23 +: 8] = 8'd255;
    depth_flat[8*0 +: 8]  = 8'd1;
    while (edge_cnt % 2048 != 0) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL edge_pre got=%h/%h/%b exp=%h/%h/%b", sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
    end
    lit7 = 0; lit0 = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL edge_scan i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (digit === 8'h7F && sseg === 8'hF9) lit7++;
      if (digit === 8'hFE && sseg !== 8'hFF) lit0++;
    end
    total++;
    if (lit7 != 253 || lit0 != 0) begin
      bad++;
      $display("FAIL edge_duty got=%0d dig0=%0d exp=253 dig0=0", lit7, lit0);
    end
  endtask

  task automatic test_midframe_update();
    int lit_a;
    int lit_b;
    depth_flat = '0;
    depth_flat[8*4 +: 8] = 8'd128;
    while (edge_cnt % 2048 != 0) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL mid_pre got=%h/%h/%b exp=%h/%h/%b", sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
    end
    lit_a = 0;
    for (int i = 0; i < 868; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL mid_a i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (digit === 8'hFD && sseg === 8'hB6) lit_a++;
    end
    depth_flat[8*4 +: 8] = 8'd255;
    while (edge_cnt % 2048 != 0) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL mid_rest got=%h/%h/%b exp=%h/%h/%b", sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (digit === 8'hFD && sseg === 8'hB6) lit_a++;
    end
    total++;
    if (lit_a != 126) begin
      bad++;
      $display("FAIL mid_old_duty got=%0d exp=126", lit_a);
    end
    lit_b = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL mid_b i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (digit === 8'hFD && sseg === 8'hB6) lit_b++;
    end
    total++;
    if (lit_b != 253) begin
      bad++;
      $display("FAIL mid_new_duty got=%0d exp=253", lit_b);
    end
  endtask

  task automatic test_async_reset();
    while (edge_cnt % 2048 != 0) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL async_pre got=%h/%h/%b exp=%h/%h/%b", sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
    end
    for (int i = 0; i < 306; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL async_run i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
    end
    total++;
    if (sseg !== 8'hB6 || digit !== 8'hFD) begin
      bad++;
      $display("FAIL async_lit got=%h/%h exp=B6/FD", sseg, digit);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs() !== obs_t'({8'hFF, 8'hFF, 1'b0})) begin
      bad++;
      $display("FAIL async_immediate got=%h/%h/%b exp=FF/FF/0", sseg, digit, frame_start);
    end
    repeat (3) @(negedge clk);
    release_reset();
    for (int i = 0; i < 600; i++) begin
      step();
      total++;
      if (obs() !== exp_o) begin
        bad++;
        $display("FAIL async_restart i=%0d got=%h/%h/%b exp=%h/%h/%b", i, sseg, digit, frame_start, exp_o.sseg, exp_o.digit, exp_o.fs);
      end
      if (i == 0) begin
        total++;
        if (frame_start !== 1'b1) begin
          bad++;
          $display("FAIL async_restart_pulse got=%b exp=1", frame_start);
        end
      end
      if (i == 2) begin
        total++;
        if (digit !== 8'hFE) begin
          bad++;
          $display("FAIL async_restart_digit got=%h exp=FE", digit);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 24; k++) m_shadow[k] = 8'h00;
    test_reset();
    test_dark_scan();
    test_single_zone();
    test_full_and_min();
    test_midframe_update();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
